pattern_count_engine: RTL and testbench
=======================================

// Module: pattern_count_engine
// PURPOSE
//  Hardware responder for the program-3 request/ack protocol: on start, reads a
//  NUM_BYTES message and a 5-bit pattern from data memory, computes the three
//  program-3 counts, writes them back to memory, then raises done.
//  Sits beside data memory as an accelerator; the core or bench issues start and
//  waits on done.
// PARAMETERS
//  NUM_BYTES  32  message length in bytes, at addresses 0..NUM_BYTES-1 (legal 2..32)
//  PAT_ADDR   32  pattern byte address; pattern = mem[PAT_ADDR][7:3]
//  RES_ADDR   33  result base: RES_ADDR+0 ctb, +1 cto, +2 cts
// PORTS
//  clk          in   1  clock, all state on rising edge
//  reset        in   1  asynchronous, active-high; returns block to IDLE
//  start        in   1  request; sampled only in IDLE or DONE
//  done         out  1  ack; high from result write-back until next start or reset
//  mem_addr     out  8  memory address, read or write
//  mem_rd_data  in   8  memory read data, combinational (valid same cycle as mem_addr)
//  mem_wr_en    out  1  one-cycle write strobe
//  mem_wr_data  out  8  write data
// BEHAVIOUR
//  - Reset: state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counters=0.
//  - FSM: IDLE -start-> LOAD_PAT -> SCAN(x NUM_BYTES) -> WR_CTB -> WR_CTO -> WR_CTS -> DONE.
//    DONE -start-> LOAD_PAT. No start: stay in IDLE/DONE.
//  - LOAD_PAT: mem_addr=PAT_ADDR; pat<=mem_rd_data[7:3]; ctb/cto/cts cleared; idx<=0.
//  - SCAN byte i: mem_addr=i; byte b=mem_rd_data.
//    ctb += matches among b[4:0],b[5:1],b[6:2],b[7:3]; cto += 1 if any matched.
//    cts: message is one bit string, byte 0 most significant, MSB first.
//    cts += the 4 in-byte matches; for i>0, also the 4 crossing windows of
//    {prev[3:0],b} at bits [11:7],[10:6],[9:5],[8:4].
//    prev <= b. Total windows = 4+8*(NUM_BYTES-1) (252 for 32).
//  - Per-byte increments: ctb adds 0..4; cto adds 0..1; cts adds 0..8.
//    All counters 8 bits, unsigned. Max ctb 128, cto 32, cts 252: no overflow.
//  - WR_CTB/WR_CTO/WR_CTS:
//    mem_wr_en=1, mem_addr=RES_ADDR+{0,1,2}, mem_wr_data=ctb/cto/cts.
//    One write per state; no writes in any other state.
//  - Outputs are Moore decodes of state/idx; mem_wr_en=0 and mem_addr=0 in IDLE/DONE.
//  - done registered: rises on the 36th rising edge after the edge sampling start (NUM_BYTES=32).
//    Latency = NUM_BYTES+4 edges. Held high in DONE.
//    Falls on the edge that samples the next start.
//  - start in LOAD_PAT..WR_CTS: see CONFIGURATION.
//    Holding start high in DONE starts a new run every completion.
//  - Reset mid-run: abort immediately.
//    Memory results partially written or untouched; done=0.
// CONFIGURATION
//  PATCNT_RESTART_EN defined:
//    start sampled in any busy state restarts at LOAD_PAT next cycle.
//    Counters cleared; no result writes from the aborted run.
//  PATCNT_RESTART_EN undefined: start ignored while busy; run completes unchanged.
// TESTING
//  1 all bytes 0x00, mem[32]=0x00 (pat 00000), pulse start
//    -> mem[33]=128, mem[34]=32, mem[35]=252, done=1.
//  2 all bytes 0x55, pat 10101 (mem[32]=0xA8)
//    -> ctb=64, cto=32, cts=126; also all 0xFF with pat 11111 -> 128,32,252.
//  3 byte0=0x0C, byte1=0x80, rest 0x00, pat 11001 (mem[32]=0xC8)
//    -> ctb=0, cto=0, cts=1 (crossing-only match).
//  4 random 32 bytes, pat 11001 -> all three counts equal a bit-accurate software model.
//    done rises exactly 36 edges after start and stays high.
//  5 reset asserted during SCAN byte 10 -> done=0, no mem_wr_en pulse; then fresh start gives correct counts.
//  6 start pulse during SCAN:
//    default build -> ignored, results as case 4.
//    PATCNT_RESTART_EN build -> done delayed by restart, still correct, exactly 3 writes.

Source files
------------

// File: rtl/pattern_count_engine.sv
// -----------------------------------------------------------------------------
// pattern_count_engine
//
// Memory-side accelerator for the program-3 request/ack protocol. On start it
// reads a 5-bit pattern (mem[PAT_ADDR][7:3]) and a NUM_BYTES message
// (mem[0..NUM_BYTES-1]). It computes three counts and writes them to
// RES_ADDR+0..2, then raises done:
//   ctb : number of pattern matches inside single bytes (4 windows per byte)
//   cto : number of bytes that contain at least one in-byte match
//   cts : matches over the whole message treated as one MSB-first bit string
//
// Optional build macro: PATCNT_RESTART_EN
//   defined   -> start seen in any busy state restarts the run at LOAD_PAT
//   undefined -> start is ignored while busy
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_reset        asynchronous active-high reset, returns to IDLE
//   i_start        request, sampled in IDLE/DONE (and busy states if restart)
//   o_done         ack, high from result write-back until next start/reset
//   o_mem_addr     memory address for reads and writes
//   i_mem_rd_data  combinational memory read data for o_mem_addr
//   o_mem_wr_en    one-cycle write strobe
//   o_mem_wr_data  write data
// -----------------------------------------------------------------------------
module pattern_count_engine #(
    parameter int NUM_BYTES = 32,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    output logic       o_done,
    output logic [7:0] o_mem_addr,
    input  logic [7:0] i_mem_rd_data,
    output logic       o_mem_wr_en,
    output logic [7:0] o_mem_wr_data
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0] PAT_A = 8'(PAT_ADDR);
    localparam logic [7:0] RES_A0 = 8'(RES_ADDR);
    localparam logic [7:0] RES_A1 = 8'(RES_ADDR + 1);
    localparam logic [7:0] RES_A2 = 8'(RES_ADDR + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_PAT,
        S_SCAN,
        S_WR_CTB,
        S_WR_CTO,
        S_WR_CTS,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_pat;
    logic [3:0]       r_prev;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_ctb;
    logic [7:0]       r_cto;
    logic [7:0]       r_cts;
    logic             r_done;

    // ------------------------------------------------------------------
    // Window matching on the byte currently presented by memory.
    // Crossing windows straddle the previous byte's low nibble and the
    // current byte's high bits: {prev[3:0], b} bits [8:4] .. [11:7].
    // ------------------------------------------------------------------
    logic [3:0]  w_in_match;
    logic [3:0]  w_x_match;
    logic [11:0] w_cat;
    logic [7:0]  w_in_cnt;
    logic [7:0]  w_x_cnt;
    logic [7:0]  w_cts_inc;

    assign w_cat = {r_prev, i_mem_rd_data};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            assign w_in_match[gi] = (i_mem_rd_data[gi+4:gi] == r_pat);
            assign w_x_match[gi]  = (w_cat[gi+8:gi+4] == r_pat);
        end
    endgenerate

    assign w_in_cnt = {7'd0, w_in_match[0]} + {7'd0, w_in_match[1]}
                    + {7'd0, w_in_match[2]} + {7'd0, w_in_match[3]};
    assign w_x_cnt  = {7'd0, w_x_match[0]} + {7'd0, w_x_match[1]}
                    + {7'd0, w_x_match[2]} + {7'd0, w_x_match[3]};
    // Byte 0 has no predecessor, so its crossing windows do not exist.
    assign w_cts_inc = w_in_cnt + ((r_idx != '0) ? w_x_cnt : 8'd0);

    // ------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        o_mem_addr    = 8'd0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_data = 8'd0;

        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_LOAD_PAT;
            end
            S_LOAD_PAT: begin
                o_mem_addr   = PAT_A;
                w_state_next = S_SCAN;
            end
            S_SCAN: begin
                o_mem_addr = {{(8-IDX_W){1'b0}}, r_idx};
                if (r_idx == LAST_IDX) w_state_next = S_WR_CTB;
            end
            S_WR_CTB: begin
                o_mem_addr    = RES_A0;
                o_mem_wr_en   = 1'b1;
                o_mem_wr_data = r_ctb;
                w_state_next  = S_WR_CTO;
            end
            S_WR_CTO: begin
                o_mem_addr    = RES_A1;
                o_mem_wr_en   = 1'b1;
                o_mem_wr_data = r_cto;
                w_state_next  = S_WR_CTS;
            end
            S_WR_CTS: begin
                o_mem_addr    = RES_A2;
                o_mem_wr_en   = 1'b1;
                o_mem_wr_data = r_cts;
                w_state_next  = S_DONE;
            end
            S_DONE: begin
                if (i_start) w_state_next = S_LOAD_PAT;
            end
            default: w_state_next = S_IDLE;
        endcase

`ifdef PATCNT_RESTART_EN
        // Busy-state restart; LOAD_PAT clears the counters so nothing from
        // the abandoned run survives.
        if (i_start && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_state_next = S_LOAD_PAT;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State, datapath and done registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pat   <= 5'd0;
            r_prev  <= 4'd0;
            r_idx   <= '0;
            r_ctb   <= 8'd0;
            r_cto   <= 8'd0;
            r_cts   <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // done tracks the state being entered, so it rises with the
            // last write and drops on the edge that accepts a new start.
            r_done  <= (w_state_next == S_DONE);

            case (r_state)
                S_LOAD_PAT: begin
                    r_pat <= i_mem_rd_data[7:3];
                    r_ctb <= 8'd0;
                    r_cto <= 8'd0;
                    r_cts <= 8'd0;
                    r_idx <= '0;
                end
                S_SCAN: begin
                    r_ctb  <= r_ctb + w_in_cnt;
                    r_cto  <= r_cto + {7'd0, |w_in_match};
                    r_cts  <= r_cts + w_cts_inc;
                    r_prev <= i_mem_rd_data[3:0];
                    if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_done = r_done;

endmodule

// File: tb/tb_pattern_count_engine.sv
module tb_pattern_count_engine;

    localparam int NB = 32;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       wen;
    logic [7:0] wdata;

    logic [7:0] mem [0:255];
    logic [7:0] wl_addr [0:15];
    logic [7:0] wl_data [0:15];
    int         wr_count = 0;

    int total = 0;
    int bad   = 0;

    pattern_count_engine #(.NUM_BYTES(NB), .PAT_ADDR(32), .RES_ADDR(33)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .o_done        (done),
        .o_mem_addr    (addr),
        .i_mem_rd_data (rdata),
        .o_mem_wr_en   (wen),
        .o_mem_wr_data (wdata)
    );

    always #5 clk = ~clk;

    assign rdata = mem[addr];

    // Write log: the message memory is never modified, results are logged.
    always @(posedge clk) begin
        if (wen) begin
            wl_addr[wr_count % 16] <= addr;
            wl_data[wr_count % 16] <= wdata;
            wr_count <= wr_count + 1;
        end
    end

    // Three logged writes starting at write number base, as {addr,data} x3.
    function automatic logic [47:0] got_res(input int base);
        return {wl_addr[base % 16], wl_data[base % 16],
                wl_addr[(base + 1) % 16], wl_data[(base + 1) % 16],
                wl_addr[(base + 2) % 16], wl_data[(base + 2) % 16]};
    endfunction

    // Reference: the message as one bit string, window j covers bits j..j+4.
    // In-byte windows are those starting at offset 0..3 inside a byte.
    task automatic model(output logic [7:0] ctb, output logic [7:0] cto,
                         output logic [7:0] cts);
        logic [4:0] p;
        logic       bits [0:NB*8-1];
        logic       m;
        logic       any;
        int         n_ctb, n_cto, n_cts;
        p = mem[32][7:3];
        n_ctb = 0; n_cto = 0; n_cts = 0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 8; k++) bits[b*8+k] = mem[b][7-k];
        for (int j = 0; j <= NB*8-5; j++) begin
            m = 1'b1;
            for (int t = 0; t < 5; t++) if (bits[j+t] !== p[4-t]) m = 1'b0;
            if (m) n_cts++;
        end
        for (int b = 0; b < NB; b++) begin
            any = 1'b0;
            for (int s = 0; s < 4; s++) begin
                m = 1'b1;
                for (int t = 0; t < 5; t++) if (bits[b*8+s+t] !== p[4-t]) m = 1'b0;
                if (m) begin n_ctb++; any = 1'b1; end
            end
            if (any) n_cto++;
        end
        ctb = 8'(n_ctb); cto = 8'(n_cto); cts = 8'(n_cts);
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_job(output int n, output int base);
        @(negedge clk);
        base  = wr_count;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%0d want=0", done); end
        total++; if (addr !== 8'd0)   begin bad++; $display("FAIL reset_addr got=%0d want=0", addr); end
        total++; if (wen !== 1'b0)    begin bad++; $display("FAIL reset_wen got=%0d want=0", wen); end
        total++; if (wdata !== 8'd0)  begin bad++; $display("FAIL reset_wdata got=%0d want=0", wdata); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        total++; if (done !== 1'b0 || wr_count !== 0) begin
            bad++; $display("FAIL idle_quiet done=%0d writes=%0d want 0/0", done, wr_count);
        end
        $display("test_reset: checked");
    endtask

    task automatic test_fixed(input string name, input logic [7:0] fill,
                              input logic [7:0] patb, input logic [7:0] x_ctb,
                              input logic [7:0] x_cto, input logic [7:0] x_cts);
        int n, base;
        logic [47:0] want;
        for (int i = 0; i < NB; i++) mem[i] = fill;
        mem[32] = patb;
        if (name == "crossing") begin
            mem[0] = 8'h0C; mem[1] = 8'h80;
        end
        run_job(n, base);
        want = {8'd33, x_ctb, 8'd34, x_cto, 8'd35, x_cts};
        total++; if (n !== NB + 4) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, n, NB + 4); end
        total++; if (wr_count - base !== 3) begin bad++; $display("FAIL %s_writes got=%0d want=3", name, wr_count - base); end
        total++; if (got_res(base) !== want) begin
            bad++; $display("FAIL %s_results got=%h want=%h", name, got_res(base), want);
        end
        $display("%s: ctb=%0d cto=%0d cts=%0d latency=%0d", name,
                 wl_data[base % 16], wl_data[(base+1) % 16], wl_data[(base+2) % 16], n);
    endtask

    task automatic test_random(input int iters);
        int n, base;
        logic [7:0] e_ctb, e_cto, e_cts;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
            // Low pattern-byte bits are don't-care; randomise them too.
            mem[32] = (it < iters / 2) ? {5'b11001, 3'($urandom_range(0, 7))}
                                       : 8'($urandom_range(0, 255));
            model(e_ctb, e_cto, e_cts);
            run_job(n, base);
            total++; if (n !== NB + 4) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, n, NB + 4); end
            total++; if (got_res(base) !== {8'd33, e_ctb, 8'd34, e_cto, 8'd35, e_cts}) begin
                bad++; $display("FAIL rand%0d_results got=%h want=%h", it, got_res(base),
                                {8'd33, e_ctb, 8'd34, e_cto, 8'd35, e_cts});
            end
            repeat (5) @(posedge clk); #1;
            total++; if (done !== 1'b1 || wr_count - base !== 3) begin
                bad++; $display("FAIL rand%0d_hold done=%0d writes=%0d want 1/3", it, done, wr_count - base);
            end
            $display("random %0d: pat=%b ctb=%0d cto=%0d cts=%0d", it, mem[32][7:3], e_ctb, e_cto, e_cts);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, base;
        logic [7:0] e_ctb, e_cto, e_cts;
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[32] = 8'hC8;
        @(negedge clk);
        base = wr_count;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);   // now scanning byte 10
        #1;
        rst = 1'b1;
        #1;
        total++; if (done !== 1'b0 || wen !== 1'b0 || addr !== 8'd0) begin
            bad++; $display("FAIL midreset_outputs done=%0d wen=%0d addr=%0d want 0/0/0", done, wen, addr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (40) @(posedge clk); #1;
        total++; if (wr_count - base !== 0 || done !== 1'b0) begin
            bad++; $display("FAIL midreset_quiet writes=%0d done=%0d want 0/0", wr_count - base, done);
        end
        model(e_ctb, e_cto, e_cts);
        run_job(n, base);
        total++; if (n !== NB + 4 || got_res(base) !== {8'd33, e_ctb, 8'd34, e_cto, 8'd35, e_cts}) begin
            bad++; $display("FAIL midreset_rerun latency=%0d got=%h want=%h", n, got_res(base),
                            {8'd33, e_ctb, 8'd34, e_cto, 8'd35, e_cts});
        end
        $display("reset mid-run: rerun latency=%0d", n);
    endtask

    task automatic test_start_during_scan();
        int n, base, want_n;
        logic [7:0] e_ctb, e_cto, e_cts;
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[32] = 8'hC8;
        model(e_ctb, e_cto, e_cts);
`ifdef PATCNT_RESTART_EN
        want_n = 11 + NB + 4;
`else
        want_n = NB + 4;
`endif
        @(negedge clk);
        base = wr_count;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (10) begin @(posedge clk); #1; n++; end
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        total++; if (n !== want_n) begin bad++; $display("FAIL scanstart_latency got=%0d want=%0d", n, want_n); end
        total++; if (wr_count - base !== 3) begin bad++; $display("FAIL scanstart_writes got=%0d want=3", wr_count - base); end
        total++; if (got_res(base) !== {8'd33, e_ctb, 8'd34, e_cto, 8'd35, e_cts}) begin
            bad++; $display("FAIL scanstart_results got=%h want=%h", got_res(base),
                            {8'd33, e_ctb, 8'd34, e_cto, 8'd35, e_cts});
        end
        $display("start during scan: latency=%0d writes=%0d", n, wr_count - base);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        test_reset();
        test_fixed("zeros",    8'h00, 8'h00, 8'd128, 8'd32, 8'd252);
        test_fixed("fives",    8'h55, 8'hA8, 8'd64,  8'd32, 8'd126);
        test_fixed("ones",     8'hFF, 8'hF8, 8'd128, 8'd32, 8'd252);
        test_fixed("crossing", 8'h00, 8'hC8, 8'd0,   8'd0,  8'd1);
        test_random(6);
        test_reset_mid_run();
        test_start_during_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
